preserve_pipe: RTL and testbench

//  Parametrised elastic pipeline with per-stage hold. Generalises the 16-bit
//  now/next preserve select into a WIDTH-bit, STAGES-deep register chain.

---
 rtl/preserve_pipe.sv | 94 +++++++++
 tb/tb_preserve_pipe.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/preserve_pipe.sv
// preserve_pipe: elastic register chain in which every stage either loads its
// upstream value or keeps its own. Bubbles collapse, so a gap anywhere lets
// every stage upstream of it move. Flush kills all stages and clears the
// stall counter.
module preserve_pipe #(
  parameter int               WIDTH     = 16,
  parameter int               STAGES    = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = 8,
  localparam int              OCC_W     = $clog2(STAGES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OCC_W-1:0] occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] src_valid;
  logic [WIDTH-1:0]  d        [STAGES];
  logic [WIDTH-1:0]  src_data [STAGES];

  // A stage may advance when the output drains or any stage from it to the
  // output is empty. Written as a reduction so there is no combinational
  // self-reference along the chain.
  for (genvar g = 0; g < STAGES; g++) begin : g_adv
    assign adv[g] = out_ready | ~(&v[STAGES-1:g]);
  end

  assign in_ready  = adv[0] & ~flush;
  assign out_valid = v[STAGES-1];
  assign out_data  = d[STAGES-1];

  // Source of each stage: the input port for stage 0, the previous stage otherwise.
  always_comb begin
    src_valid[0] = in_valid;
    src_data[0]  = in_data;
    for (int i = 1; i < STAGES; i++) begin
      src_valid[i] = v[i-1];
      src_data[i]  = d[i-1];
    end
  end

  // Stage registers: load on advance, otherwise preserve; flush clears valids only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= '0;
      for (int i = 0; i < STAGES; i++) begin
        d[i] <= RESET_VAL;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (flush) begin
          v[i] <= 1'b0;
        end else if (adv[i]) begin
          v[i] <= src_valid[i];
        end
        if (!flush && adv[i] && src_valid[i]) begin
          d[i] <= src_data[i];
        end
      end
    end
  end

  // Saturating count of cycles where the output is held back downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (flush) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && stall_cnt != CNT_MAX) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  // Number of occupied stages.
  always_comb begin
    occupancy = '0;
    for (int i = 0; i < STAGES; i++) begin
      occupancy = occupancy + OCC_W'(v[i]);
    end
  end

endmodule

// File: tb/tb_preserve_pipe.sv
// tb_preserve_pipe: two instances (2-stage/8-bit counter and 3-stage/2-bit
// counter) driven in lockstep and compared each cycle against a slot-based
// model of the pipeline, plus directed scenarios with fixed expectations.
module tb_preserve_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] in_data;

  logic        rdy_a, vld_a, rdy_b, vld_b;
  logic [15:0] dat_a, dat_b;
  logic [1:0]  occ_a, occ_b;
  logic [7:0]  stl_a;
  logic [1:0]  stl_b;

  int n_chk = 0;
  int n_err = 0;

  preserve_pipe #(.WIDTH(16), .STAGES(2), .RESET_VAL(16'hDEAD), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_a), .out_data(dat_a), .out_valid(vld_a), .out_ready(out_ready),
    .occupancy(occ_a), .stall_cnt(stl_a)
  );

  preserve_pipe #(.WIDTH(16), .STAGES(3), .RESET_VAL(16'h0055), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_b), .out_data(dat_b), .out_valid(vld_b), .out_ready(out_ready),
    .occupancy(occ_b), .stall_cnt(stl_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: slots per instance, items shift one place toward the
  // output whenever the place ahead is (or becomes) free.
  bit        mv [2][4];
  bit [15:0] md [2][4];
  int        sc [2];
  int        ns   [2] = '{2, 3};
  int        cmax [2] = '{255, 3};

  function automatic void mdl_reset();
    for (int k = 0; k < 2; k++) begin
      sc[k] = 0;
      for (int j = 0; j < 4; j++) mv[k][j] = 1'b0;
    end
  endfunction

  // Stage 0 can take a word unless flushing or the pipe is full and jammed.
  function automatic bit mdl_ready(int k);
    if (flush) return 1'b0;
    if (out_ready) return 1'b1;
    for (int j = 0; j < ns[k]; j++) if (!mv[k][j]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int mdl_occ(int k);
    int n;
    n = 0;
    for (int j = 0; j < ns[k]; j++) n += int'(mv[k][j]);
    return n;
  endfunction

  function automatic void mdl_step(int k);
    int last;
    bit acc;
    last = ns[k] - 1;
    acc  = mdl_ready(k) && in_valid;
    if (flush) sc[k] = 0;
    else if (mv[k][last] && !out_ready && sc[k] < cmax[k]) sc[k]++;
    if (mv[k][last] && out_ready) mv[k][last] = 1'b0;
    for (int j = last - 1; j >= 0; j--) begin
      if (mv[k][j] && !mv[k][j+1]) begin
        mv[k][j+1] = 1'b1;
        md[k][j+1] = md[k][j];
        mv[k][j]   = 1'b0;
      end
    end
    if (flush) begin
      for (int j = 0; j < 4; j++) mv[k][j] = 1'b0;
    end else if (acc) begin
      mv[k][0] = 1'b1;
      md[k][0] = in_data;
    end
  endfunction

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      logic        g_r, g_v;
      logic [15:0] g_d;
      int          g_o, g_s, last;
      last = ns[k] - 1;
      g_r = (k == 0) ? rdy_a : rdy_b;
      g_v = (k == 0) ? vld_a : vld_b;
      g_d = (k == 0) ? dat_a : dat_b;
      g_o = (k == 0) ? int'(occ_a) : int'(occ_b);
      g_s = (k == 0) ? int'(stl_a) : int'(stl_b);
      chk($sformatf("in_ready[%0d]", k), g_r, mdl_ready(k));
      chk($sformatf("out_valid[%0d]", k), g_v, mv[k][last]);
      chk($sformatf("occupancy[%0d]", k), g_o, mdl_occ(k));
      chk($sformatf("stall_cnt[%0d]", k), g_s, sc[k]);
      if (mv[k][last]) chk($sformatf("out_data[%0d]", k), g_d, md[k][last]);
    end
  endtask

  // One clock: check outputs just after the inputs settle, then advance the model.
  task automatic cycle();
    #1;
    check_all();
    @(posedge clk);
    mdl_step(0);
    mdl_step(1);
    @(negedge clk);
  endtask

  task automatic drive(input logic iv, input logic [15:0] id, input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
  endtask

  initial begin
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    rst = 1'b1;
    mdl_reset();
    @(negedge clk);
    #1;
    chk("rst out_data", dat_a, 16'hDEAD);
    chk("rst out_valid", vld_a, 1'b0);
    chk("rst occupancy", occ_a, 2'd0);
    chk("rst in_ready", rdy_a, 1'b1);
    chk("rst stall_cnt", stl_a, 8'd0);
    chk("rst out_data b", dat_b, 16'h0055);
    rst = 1'b0;
    @(negedge clk);

    // Streaming 1..8 with the output always ready.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 16'(i), 1'b1, 1'b0);
      if (i == 3) begin
        #1;
        chk("latency out_valid", vld_a, 1'b1);
        chk("latency out_data", dat_a, 16'h0001);
      end
      cycle();
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 16'h0, 1'b1, 1'b0);
      cycle();
    end

    // Two words held for five stalled cycles, then drained in order.
    drive(1'b0, 16'h0, 1'b1, 1'b1); cycle();
    drive(1'b1, 16'hAAAA, 1'b0, 1'b0); cycle();
    drive(1'b1, 16'hBBBB, 1'b0, 1'b0); cycle();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 16'h0, 1'b0, 1'b0);
      cycle();
    end
    #1;
    chk("hold out_data", dat_a, 16'hAAAA);
    chk("hold occupancy", occ_a, 2'd2);
    chk("hold in_ready", rdy_a, 1'b0);
    chk("hold stall_cnt", stl_a, 8'd5);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 16'h0, 1'b1, 1'b0);
      cycle();
    end

    // Bubble collapse: only the output stage full, output blocked.
    drive(1'b0, 16'h0, 1'b1, 1'b1); cycle();
    drive(1'b1, 16'h5555, 1'b0, 1'b0); cycle();
    drive(1'b0, 16'h0, 1'b0, 1'b0); cycle();
    drive(1'b1, 16'h1234, 1'b0, 1'b0);
    #1;
    chk("bubble in_ready", rdy_a, 1'b1);
    cycle();
    #1;
    chk("bubble occupancy", occ_a, 2'd2);
    chk("bubble out_data", dat_a, 16'h5555);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 16'h0, 1'b1, 1'b0);
      cycle();
    end

    // Flush with a full pipe and both sides active.
    drive(1'b0, 16'h0, 1'b1, 1'b1); cycle();
    drive(1'b1, 16'h0011, 1'b0, 1'b0); cycle();
    drive(1'b1, 16'h0022, 1'b0, 1'b0); cycle();
    drive(1'b0, 16'h0, 1'b0, 1'b0); cycle();
    drive(1'b1, 16'h0033, 1'b1, 1'b1);
    #1;
    chk("flush in_ready", rdy_a, 1'b0);
    chk("flush out_valid", vld_a, 1'b1);
    chk("flush out_data", dat_a, 16'h0011);
    cycle();
    #1;
    chk("flush occupancy", occ_a, 2'd0);
    chk("flush stall_cnt", stl_a, 8'd0);
    chk("flush out_valid after", vld_a, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 16'h0, 1'b1, 1'b0);
      cycle();
    end

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 7, 16'($urandom), $urandom_range(0, 9) < 6,
            $urandom_range(0, 19) == 0);
      cycle();
    end

    // Saturation of the narrow counter, then reset in the middle of a stall.
    drive(1'b0, 16'h0, 1'b1, 1'b1); cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0);
      cycle();
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 16'h0, 1'b0, 1'b0);
      cycle();
    end
    #1;
    chk("sat stall_cnt b", stl_b, 2'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("async out_valid", vld_a, 1'b0);
    chk("async out_data", dat_a, 16'hDEAD);
    chk("async occupancy", occ_a, 2'd0);
    chk("async in_ready", rdy_a, 1'b1);
    chk("async stall_cnt", stl_a, 8'd0);
    chk("async out_valid b", vld_b, 1'b0);
    chk("async out_data b", dat_b, 16'h0055);
    chk("async stall_cnt b", stl_b, 2'd0);
    mdl_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(i < 3, 16'h0200 + 16'(i), 1'b1, 1'b0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
